// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types and helpers for the store read-modify-write unit
package store_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } store_size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WAIT  = 2'b10,
      WRITE = 2'b11
   } store_state_e;

   // A store is legal when its size is defined and the address is naturally aligned.
   function automatic logic size_ok(input store_size_e size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: size_ok = 1'b1;
         SZ_HALF: size_ok = ~addr_lo[0];
         SZ_WORD: size_ok = (addr_lo == 2'b00);
         default: size_ok = 1'b0;
      endcase
   endfunction

   // Number of bytes written by a store of the given size.
   function automatic logic [2:0] size_bytes(input store_size_e size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - combinational little-endian byte-lane merge of store data into a memory word
module store_lane_merge
   import store_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [31:0]           store_data,
   input  store_size_e           size,
   input  logic [OFF_WIDTH-1:0]  offset,
   output logic [DATA_WIDTH-1:0] merged
);

   localparam int NBYTES = DATA_WIDTH / 8;

   int          rel;
   logic [31:0] shifted;

   // Each memory byte takes store data when it falls inside [offset, offset+size), else keeps old data.
   always_comb begin
      merged  = old_word;
      rel     = 0;
      shifted = store_data;
      for (int i = 0; i < NBYTES; i++) begin
         rel     = i - int'(offset);
         shifted = store_data >> {rel[1:0], 3'b000};
         if (rel >= 0 && rel < int'(size_bytes(size))) begin
            merged[8*i +: 8] = shifted[7:0];
         end
      end
   end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - sub-word store unit performing read-modify-write on a word-wide memory
module store_rmw_unit
   import store_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  done,
   output logic                  err
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int OFFW   = $clog2(NBYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(NBYTES - 1);

   store_state_e          state;
   store_state_e          state_nxt;
   store_size_e           req_size_e;
   logic                  req_ok;
   logic                  req_direct;
   logic                  accept;

   logic [ADDR_WIDTH-1:0] addr_q;
   store_size_e           size_q;
   logic [31:0]           wdata_q;
   logic [DATA_WIDTH-1:0] wbuf;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] merged;

   assign req_size_e = store_size_e'(req_size);
   assign req_ok     = size_ok(req_size_e, req_addr[1:0]);
   // A full-word store on a 32-bit memory overwrites every byte, so the read is skipped.
   assign req_direct = (DATA_WIDTH == 32) && (req_size_e == SZ_WORD);
   assign accept     = req_valid && req_ready;

   assign mem_addr   = addr_q & ALIGN_MASK;
   assign mem_wdata  = wbuf;
   assign err        = err_q;

   store_lane_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .OFF_WIDTH  (OFFW)
   ) u_merge (
      .old_word   (mem_rdata),
      .store_data (wdata_q),
      .size       (size_q),
      .offset     (addr_q[OFFW-1:0]),
      .merged     (merged)
   );

   // State register; reset aborts any store in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and memory strobes decoded from the current state.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && req_ok) begin
               state_nxt = req_direct ? WRITE : READ;
            end
         end
         READ: begin
            mem_re    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            state_nxt = WRITE;
         end
         WRITE: begin
            mem_we    = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, error pulse and write buffer (direct data or merged read data).
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         size_q  <= SZ_BYTE;
         wdata_q <= '0;
         wbuf    <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept && !req_ok;
         if (accept && req_ok) begin
            addr_q  <= req_addr;
            size_q  <= req_size_e;
            wdata_q <= req_wdata;
            if (req_direct) begin
               wbuf <= DATA_WIDTH'(req_wdata);
            end
         end
         if (state == WAIT) begin
            wbuf <= merged;
         end
      end
   end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - scoreboard bench for store_rmw_unit at 32- and 64-bit memory widths
module tb_store_rmw_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v32 = 1'b0;
   logic        v64 = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;

   logic        r32_ready, m32_re, m32_we, d32, e32;
   logic [31:0] m32_addr, m32_wdata;
   logic [31:0] m32_rdata = 32'h0;
   logic        r64_ready, m64_re, m64_we, d64, e64;
   logic [31:0] m64_addr;
   logic [63:0] m64_wdata;
   logic [63:0] m64_rdata = 64'h0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t         q32[$];
   wr_t         q64[$];
   wr_t         w32;
   wr_t         w64;
   logic [31:0] mem32 [logic [31:0]];
   logic [63:0] mem64 [logic [31:0]];

   always #5 clk = ~clk;

   store_rmw_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .req_valid(v32), .req_ready(r32_ready), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(m32_addr), .mem_re(m32_re),
      .mem_rdata(m32_rdata), .mem_we(m32_we), .mem_wdata(m32_wdata), .done(d32), .err(e32)
   );

   store_rmw_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
      .clk(clk), .rst(rst), .req_valid(v64), .req_ready(r64_ready), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(m64_addr), .mem_re(m64_re),
      .mem_rdata(m64_rdata), .mem_we(m64_we), .mem_wdata(m64_wdata), .done(d64), .err(e64)
   );

   function automatic logic [31:0] rd32(input logic [31:0] a);
      return mem32.exists(a) ? mem32[a] : 32'h0;
   endfunction

   function automatic logic [63:0] rd64(input logic [31:0] a);
      return mem64.exists(a) ? mem64[a] : 64'h0;
   endfunction

   function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input int off);
      logic [63:0] mask;
      mask = (sz == 2'd0) ? 64'hFF : (sz == 2'd1) ? 64'hFFFF : 64'hFFFF_FFFF;
      return (old & ~(mask << (8 * off))) | (({32'h0, wd} & mask) << (8 * off));
   endfunction

   // memory models: read data one cycle after mem_re, junk otherwise
   always @(posedge clk) begin
      m32_rdata <= m32_re ? rd32(m32_addr) : 32'hA5A5_A5A5;
      m64_rdata <= m64_re ? rd64(m64_addr) : 64'hA5A5_A5A5_5A5A_5A5A;
   end

   // scoreboard: every write must match the oldest expected write
   always @(negedge clk) begin
      if (m32_we) begin
         checks++;
         if (m32_re) begin
            errors++;
            $display("FAIL w32_re_we_overlap: re=%0b we=%0b required not both", m32_re, m32_we);
         end else if (q32.size() == 0) begin
            errors++;
            $display("FAIL w32_unexpected: addr=%h data=%h required no write", m32_addr, m32_wdata);
         end else begin
            w32 = q32.pop_front();
            if (m32_addr !== w32.addr || m32_wdata !== w32.data[31:0]) begin
               errors++;
               $display("FAIL w32_data: addr=%h data=%h required addr=%h data=%h",
                        m32_addr, m32_wdata, w32.addr, w32.data[31:0]);
            end
            mem32[w32.addr] = w32.data[31:0];
         end
      end
      if (m64_we) begin
         checks++;
         if (m64_re) begin
            errors++;
            $display("FAIL w64_re_we_overlap: re=%0b we=%0b required not both", m64_re, m64_we);
         end else if (q64.size() == 0) begin
            errors++;
            $display("FAIL w64_unexpected: addr=%h data=%h required no write", m64_addr, m64_wdata);
         end else begin
            w64 = q64.pop_front();
            if (m64_addr !== w64.addr || m64_wdata !== w64.data) begin
               errors++;
               $display("FAIL w64_data: addr=%h data=%h required addr=%h data=%h",
                        m64_addr, m64_wdata, w64.addr, w64.data);
            end
            mem64[w64.addr] = w64.data;
         end
      end
   end

   // one store on the chosen unit, checking strobe/ready/err timing relative to acceptance
   task automatic do_store(input bit wide, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag);
      int re_at = 0, we_at = 0, done_at = 0, err_at = 0, rdy_at = 0, waited = 0;
      int e_re, e_we, e_rdy, e_err;
      bit bad, direct, re_now, rdy_now;
      logic [31:0] a_al, a_now;
      bad    = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
      direct = !wide && (sz == 2'd2);
      a_al   = wide ? (addr & ~32'h7) : (addr & ~32'h3);
      @(negedge clk);
      while (!(wide ? r64_ready : r32_ready) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 20) begin
         errors++;
         $display("FAIL %s_ready_timeout: waited %0d cycles required ready", tag, waited);
      end
      req_size  = sz;
      req_addr  = addr;
      req_wdata = wd;
      if (wide) v64 = 1'b1; else v32 = 1'b1;
      if (!bad) begin
         if (wide) q64.push_back('{a_al, ref_merge(rd64(a_al), wd, sz, int'(addr[2:0]))});
         else      q32.push_back('{a_al, ref_merge({32'h0, rd32(a_al)}, wd, sz, int'(addr[1:0]))});
      end
      @(posedge clk);
      #1;
      v32 = 1'b0;
      v64 = 1'b0;
      req_size  = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         re_now  = wide ? m64_re : m32_re;
         rdy_now = wide ? r64_ready : r32_ready;
         a_now   = wide ? m64_addr : m32_addr;
         if (re_now && re_at == 0) re_at = k;
         if ((wide ? m64_we : m32_we) && we_at == 0) we_at = k;
         if ((wide ? d64 : d32) && done_at == 0) done_at = k;
         if ((wide ? e64 : e32) && err_at == 0) err_at = k;
         if (rdy_now && rdy_at == 0) rdy_at = k;
         if (re_now) begin
            checks++;
            if (a_now !== a_al) begin
               errors++;
               $display("FAIL %s_read_addr: got %h required %h", tag, a_now, a_al);
            end
         end
      end
      if (bad)         begin e_re = 0; e_we = 0; e_rdy = 1; e_err = 1; end
      else if (direct) begin e_re = 0; e_we = 1; e_rdy = 2; e_err = 0; end
      else             begin e_re = 1; e_we = 3; e_rdy = 4; e_err = 0; end
      checks++;
      if (re_at != e_re) begin
         errors++;
         $display("FAIL %s_re_cycle: got %0d required %0d", tag, re_at, e_re);
      end
      checks++;
      if (we_at != e_we) begin
         errors++;
         $display("FAIL %s_we_cycle: got %0d required %0d", tag, we_at, e_we);
      end
      checks++;
      if (done_at != e_we) begin
         errors++;
         $display("FAIL %s_done_cycle: got %0d required %0d", tag, done_at, e_we);
      end
      checks++;
      if (err_at != e_err) begin
         errors++;
         $display("FAIL %s_err_cycle: got %0d required %0d", tag, err_at, e_err);
      end
      checks++;
      if (rdy_at != e_rdy) begin
         errors++;
         $display("FAIL %s_ready_cycle: got %0d required %0d", tag, rdy_at, e_rdy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({r32_ready, m32_re, m32_we, d32, e32} !== 5'b10000) begin
         errors++;
         $display("FAIL reset32: rdy/re/we/done/err=%b required 10000",
                  {r32_ready, m32_re, m32_we, d32, e32});
      end
      checks++;
      if ({r64_ready, m64_re, m64_we, d64, e64} !== 5'b10000) begin
         errors++;
         $display("FAIL reset64: rdy/re/we/done/err=%b required 10000",
                  {r64_ready, m64_re, m64_we, d64, e64});
      end
   endtask

   task automatic test_spec_vectors();
      do_store(1'b0, 2'd2, 32'h100, 32'hDEADBEEF, "sw_direct");
      mem32[32'h100] = 32'h11223344;
      do_store(1'b0, 2'd0, 32'h103, 32'h000000AA, "sb_103");
      mem32[32'h200] = 32'h11223344;
      do_store(1'b0, 2'd1, 32'h202, 32'h0000BEEF, "sh_202");
      do_store(1'b0, 2'd1, 32'h201, 32'h0000BEEF, "sh_misaligned");
      do_store(1'b0, 2'd2, 32'h102, 32'h12345678, "sw_misaligned");
      do_store(1'b0, 2'd3, 32'h100, 32'h12345678, "size_rsvd");
   endtask

   task automatic test_dw64();
      mem64[32'h100] = 64'h1111111122222222;
      do_store(1'b1, 2'd2, 32'h104, 32'hCAFEF00D, "dw64_sw_104");
      do_store(1'b1, 2'd0, 32'h107, 32'h00000077, "dw64_sb_107");
      do_store(1'b1, 2'd1, 32'h102, 32'h0000ABCD, "dw64_sh_102");
      do_store(1'b1, 2'd2, 32'h106, 32'h0, "dw64_sw_misaligned");
   endtask

   task automatic test_random();
      logic [1:0]  sz;
      logic [31:0] off, base;
      for (int i = 0; i < 8; i++) begin
         mem32[32'h400 + 4 * i] = $urandom;
         mem64[32'h400 + 8 * i] = {$urandom, $urandom};
      end
      for (int i = 0; i < 24; i++) begin
         bit wide;
         wide = (i % 3 == 2);
         sz   = 2'($urandom_range(0, 2));
         base = 32'h400 + ($urandom_range(0, 7) * (wide ? 8 : 4));
         off  = $urandom_range(0, wide ? 7 : 3);
         if (sz == 2'd1) off = off & ~32'h1;
         if (sz == 2'd2) off = off & ~32'h3;
         do_store(wide, sz, base + off, $urandom, wide ? "rand64" : "rand32");
      end
   endtask

   task automatic test_reset_mid();
      bit we_seen = 0;
      mem32[32'h500] = 32'h01020304;
      @(negedge clk);
      req_size  = 2'd0;
      req_addr  = 32'h501;
      req_wdata = 32'h000000EE;
      v32 = 1'b1;
      @(posedge clk);
      #1;
      v32 = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (r32_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready: got %b required 1", r32_ready);
      end
      for (int k = 0; k < 6; k++) begin
         if (m32_we) we_seen = 1;
         @(negedge clk);
      end
      checks++;
      if (we_seen) begin
         errors++;
         $display("FAIL rst_mid_write: got write after reset required none");
      end
   endtask

   task automatic test_rst_priority();
      bit re_seen = 0;
      @(negedge clk);
      rst       = 1'b1;
      v32       = 1'b1;
      req_size  = 2'd0;
      req_addr  = 32'h600;
      req_wdata = 32'h55;
      @(posedge clk);
      #1;
      rst = 1'b0;
      v32 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (m32_re || m32_we || e32) re_seen = 1;
      end
      checks++;
      if (re_seen) begin
         errors++;
         $display("FAIL rst_priority: got memory access/err required none");
      end
   endtask

   task automatic test_back_to_back();
      int we1 = 0, we2 = 0, re_cnt = 0, acc2 = 0;
      bit dropped = 0;
      mem32[32'h300] = 32'h55667788;
      @(negedge clk);
      req_size  = 2'd0;
      req_addr  = 32'h301;
      req_wdata = 32'h00000011;
      v32 = 1'b1;
      q32.push_back('{32'h300, {32'h0, 32'h55661188}});
      @(posedge clk);
      #1;
      req_size  = 2'd2;
      req_addr  = 32'h304;
      req_wdata = 32'h12345678;
      q32.push_back('{32'h304, {32'h0, 32'h12345678}});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (m32_re) re_cnt++;
         if (m32_we && we1 == 0) we1 = k;
         else if (m32_we && we2 == 0) we2 = k;
         if (r32_ready && !dropped) begin
            acc2 = k;
            dropped = 1;
            @(posedge clk);
            #1;
            v32 = 1'b0;
         end
      end
      v32 = 1'b0;
      checks++;
      if (acc2 != 4) begin
         errors++;
         $display("FAIL b2b_accept: second accepted at %0d required 4", acc2);
      end
      checks++;
      if (we1 != 3 || we2 != 5 || re_cnt != 1) begin
         errors++;
         $display("FAIL b2b_timing: we1=%0d we2=%0d re_cnt=%0d required 3 5 1", we1, we2, re_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_spec_vectors();
      test_dw64();
      test_random();
      test_reset_mid();
      test_rst_priority();
      test_back_to_back();
      repeat (4) @(negedge clk);
      checks++;
      if (q32.size() != 0 || q64.size() != 0) begin
         errors++;
         $display("FAIL pending_writes: q32=%0d q64=%0d required 0 0", q32.size(), q64.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
